// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Bundles the instruction-memory handshake, the redirect request and the
//   decode valid/ready interface of the fetch stage.
//   master : the fetch stage (drives imem_req/imem_addr and dec_*).
//   slave  : the environment (memory, branch unit and decode).
//   Signals:
//     imem_req, imem_addr      read request and word-aligned address
//     imem_ack, imem_rdata     one-cycle completion pulse and instruction word
//     redirect_valid/_pc       one-cycle flush-and-restart request
//     dec_valid/_instr/_pc     head entry of the fetch queue
//     dec_ready                decode accepts the head entry
interface fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch stage. Owns the PC, issues single outstanding word reads
//   to instruction memory and buffers {pc, instr} pairs in a QDEPTH-entry FIFO
//   that feeds decode. A redirect flushes the FIFO, reloads the PC and turns a
//   still-outstanding request into one whose response is thrown away.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  fetch_queue_if.master (imem handshake, redirect, decode handshake)
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  fetch_queue_if.master    bus
);

  localparam int              PW        = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int              CW        = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C   = CW'(QDEPTH);
  localparam logic [31:0]     ALIGN_M   = 32'hFFFF_FFFC;
  localparam logic [31:0]     START_PC  = RESET_PC & ALIGN_M;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [31:0]     pc_r;
  logic [31:0]     addr_r;
  logic [31:0]     mem_instr_r [QDEPTH];
  logic [31:0]     mem_pc_r    [QDEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            issue_s;
  logic            push_s;
  logic            pop_s;
  logic            empty_s;

  assign empty_s = (count_r == {CW{1'b0}});

  // Next-state, issue and push decisions; redirect outranks everything else.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    push_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // Nothing is outstanding in IDLE, so count alone decides whether
        // there is room reserved for the response of a new request.
        if (bus.redirect_valid) begin
          state_s = IDLE;
        end else if (count_r < DEPTH_C) begin
          state_s = WAIT;
          issue_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          // A coincident ack completes the request, its data is dropped.
          if (bus.imem_ack) begin
            state_s = IDLE;
          end else begin
            state_s = DISCARD;
          end
        end else if (bus.imem_ack) begin
          state_s = IDLE;
          push_s  = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      DISCARD: begin
        // Leave on the ack even if a further redirect arrives with it, so the
        // FSM never waits for a response that will not come.
        if (bus.imem_ack) begin
          state_s = IDLE;
        end else begin
          state_s = DISCARD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    pop_s = !empty_s && bus.dec_ready && !bus.redirect_valid;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // PC, request address, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= START_PC;
      addr_r   <= START_PC;
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (bus.redirect_valid) begin
        pc_r <= bus.redirect_pc & ALIGN_M;
      end else if (push_s) begin
        pc_r <= pc_r + 32'd4;
      end
      // The address is latched at issue so it stays stable while pc moves
      // under a redirect during DISCARD.
      if (issue_s) begin
        addr_r <= pc_r;
      end
      if (bus.redirect_valid) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
        count_r  <= {CW{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // FIFO storage; an entry holds the fetched word and the PC it came from.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_instr_r[i] <= NOP_INSTR;
        mem_pc_r[i]    <= 32'h0000_0000;
      end
    end else if (push_s) begin
      mem_instr_r[wr_ptr_r] <= bus.imem_rdata;
      mem_pc_r[wr_ptr_r]    <= pc_r;
    end
  end

  assign bus.imem_req  = (state_r != IDLE);
  assign bus.imem_addr = addr_r;
  assign bus.dec_valid = !empty_s;
  assign bus.dec_instr = empty_s ? NOP_INSTR : mem_instr_r[rd_ptr_r];
  assign bus.dec_pc    = empty_s ? 32'h0000_0000 : mem_pc_r[rd_ptr_r];

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage directly upstream of decode and immediate generation.
- Owns the PC and issues word reads to instruction memory over a request/ack handshake.
- Buffers returned instructions with their PCs in a small FIFO, presented to decode under valid/ready.
- Supports redirect (branch/jump) with queue flush and discard of the in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] forced to 0.
- QDEPTH, 2, FIFO entries; power of two, 2..8.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  read request; held until imem_ack.
- imem_addr  output  32  word-aligned read address; stable while imem_req=1.
- imem_ack  input  1  one-cycle pulse: request complete, imem_rdata valid.
- imem_rdata  input  32  instruction word, sampled when imem_ack=1.
- redirect_valid  input  1  one-cycle pulse: flush and restart fetch.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored.
- dec_ready  input  1  decode accepts the head entry this cycle.
- dec_valid  output  1  head entry valid.
- dec_instr  output  32  head instruction.
- dec_pc  output  32  PC of the head instruction.

Behaviour:
- Reset, sampled at clk edge while rst=1:
  - pc=RESET_PC, FIFO empty, state=IDLE, imem_req=0, dec_valid=0.
  - dec_instr=32'h0000_0013 (NOP), dec_pc=0 while empty.
  - rst mid-transaction drops the outstanding request; a later imem_ack is ignored until a new request is issued.
- FSM states IDLE, WAIT, DISCARD:
  - IDLE: if count < QDEPTH, assert imem_req with imem_addr=pc and go to WAIT. The first request after reset is visible one cycle after rst deasserts.
  - WAIT: hold imem_req and imem_addr. On imem_ack, push {pc, imem_rdata}, pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0), return to IDLE. imem_req drops in the ack cycle's successor.
  - Space is reserved at issue: a request is issued only when count + outstanding < QDEPTH, so a push never overflows.
  - DISCARD: imem_req held until imem_ack; the ack is dropped, no push; then go to IDLE.
- Back-to-back issue: a new request may issue the cycle after ack at the earliest. Single outstanding request; no pipelined requests.
- Decode interface:
  - dec_valid = FIFO non-empty; dec_instr/dec_pc show the head.
  - Pop when dec_valid && dec_ready.
  - A pushed entry becomes visible the cycle after imem_ack (no bypass).
  - Push and pop in the same cycle: count unchanged, order preserved.
- Redirect (redirect_valid=1, highest priority):
  - Flush the FIFO; the next cycle dec_valid=0.
  - pc = {redirect_pc[31:2], 2'b00}.
  - A pop in the same cycle is ignored.
  - If in WAIT without ack this cycle, go to DISCARD. If imem_ack coincides, drop the data and go to IDLE.
  - Redirect while in DISCARD: update pc, stay in DISCARD.
- Pointer wrap: read/write pointers are log2(QDEPTH) bits; count is log2(QDEPTH)+1 bits. Full/empty are distinguished by count.
- No exceptions; misaligned redirect targets are silently aligned.

Test Plan:
- Reset and stream, RESET_PC=0x100, ack 1 cycle after each req, dec_ready=1:
  - imem_addr sequence 0x100, 0x104, 0x108.
  - dec_pc/dec_instr match in order; rdata 0x0a018613 at 0x100 appears with dec_pc=0x100.
- Backpressure, dec_ready=0, QDEPTH=2:
  - Exactly two requests issue, then imem_req stays 0.
  - Raise dec_ready: entries drain in order, fetch resumes at pc+8.
- Redirect while waiting:
  - Req at 0x104 outstanding; redirect_pc=0x2002.
  - Late ack data 0xDEADBEEF never reaches dec_instr.
  - Next imem_addr=0x2000, and the first dec_pc after the flush is 0x2000.
- Redirect coincident with ack and pop:
  - FIFO holds one entry.
  - Next cycle dec_valid=0, the acked data is dropped, next req is to the redirect target.
- PC wrap: redirect to 0xFFFFFFFC, two fetches: addresses 0xFFFFFFFC then 0x00000000.
- Reset mid-WAIT:
  - Assert rst for 1 cycle with a request outstanding; a stray ack then arrives.
  - No push occurs, dec_valid=0, first new req is to RESET_PC.
